// File: rtl/simple_cpu_pkg.sv
// rtl/simple_cpu_pkg.sv - opcodes, FSM states and instruction field layout for simple_cpu_hs
package simple_cpu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NAND = 3'd1;
   localparam logic [2:0] OP_SRL  = 3'd2;
   localparam logic [2:0] OP_LT   = 3'd3;
   localparam logic [2:0] OP_CP   = 3'd4;
   localparam logic [2:0] OP_CPI  = 3'd5;
   localparam logic [2:0] OP_BZJ  = 3'd6;
   localparam logic [2:0] OP_MUL  = 3'd7;

   typedef enum logic [2:0] {
      FETCH,
      RDA,
      RDB,
      RDIND,
      EXEC,
      WRITE,
      HALT
   } cpuState_t;

   localparam int OP_HI   = 31;
   localparam int OP_LO   = 29;
   localparam int IMM_BIT = 28;
   localparam int A_HI    = 27;
   localparam int A_LO    = 14;
   localparam int B_HI    = 13;
   localparam int B_LO    = 0;

endpackage

// File: rtl/simple_cpu_alu.sv
// rtl/simple_cpu_alu.sv - combinational result unit for the data-writing opcodes
module simple_cpu_alu
   import simple_cpu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] opA,
   input  logic [DATA_W-1:0] v,
   output logic [DATA_W-1:0] result
);

   localparam logic [DATA_W-1:0] ONE_W = DATA_W'(DATA_W);
   localparam logic [DATA_W-1:0] TWO_W = DATA_W'(2 * DATA_W);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = opA + v;
         OP_NAND: result = ~(opA & v);
         // Shift amounts past one word flip to a left shift by the excess
         OP_SRL: begin
            if (v < ONE_W)
               result = opA >> v;
            else if (v < TWO_W)
               result = opA << (v - ONE_W);
            else
               result = '0;
         end
         OP_LT:   result = (opA < v) ? DATA_W'(1) : '0;
         OP_CP:   result = v;
         OP_CPI:  result = v;
         OP_MUL:  result = opA * v;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/simple_cpu_hs.sv
// rtl/simple_cpu_hs.sv - multi-cycle memory-to-memory CPU with req/ack memory handshake
module simple_cpu_hs
   import simple_cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic [CNT_W-1:0]  instr_count
);

   cpuState_t         state, nextState;
   logic [31:0]       ir;
   logic [DATA_W-1:0] opA, opB, res;
   logic [ADDR_W-1:0] pcReg, bzjTarget;
   logic [CNT_W-1:0]  cnt;

   logic [DATA_W+31:0] rdExt;
   logic [31:0]        rdWord;
   logic [2:0]         irOp, fOp;
   logic               irImm, fImm;
   logic [ADDR_W-1:0]  aAddr, bAddr;
   logic [DATA_W-1:0]  bImm, aluV, aluRes;
   logic               xferDone;
   logic               unusedBits;

   // Instruction words live in the low 32 bits regardless of DATA_W
   assign rdExt  = {32'b0, mem_rdata};
   assign rdWord = rdExt[31:0];
   assign fOp    = rdWord[OP_HI:OP_LO];
   assign fImm   = rdWord[IMM_BIT];

   assign irOp  = ir[OP_HI:OP_LO];
   assign irImm = ir[IMM_BIT];
   assign aAddr = ir[A_LO+ADDR_W-1:A_LO];
   assign bAddr = ir[B_LO+ADDR_W-1:B_LO];
   assign bImm  = DATA_W'(ir[B_HI:B_LO]);

   // CPI always moves the fetched operand, even in its imm=1 form
   assign aluV     = (irImm && irOp != OP_CPI) ? bImm : opB;
   assign xferDone = mem_req && mem_ack;

   assign unusedBits = ^{ir, rdExt};

   simple_cpu_alu #(.DATA_W(DATA_W)) alu (
      .op     (irOp),
      .opA    (opA),
      .v      (aluV),
      .result (aluRes)
   );

   always_comb begin
      bzjTarget = pcReg + ADDR_W'(1);
      if (irImm)
         bzjTarget = opA[ADDR_W-1:0] + bAddr;
      else if (opB == '0)
         bzjTarget = opA[ADDR_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= FETCH;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         FETCH: begin
            if (xferDone) begin
               if (fOp == OP_CP)
                  nextState = fImm ? EXEC : RDB;
               else if (fOp == OP_CPI && !fImm)
                  nextState = RDB;
               else
                  nextState = RDA;
            end
         end
         RDA:   if (xferDone) nextState = (irImm && irOp != OP_CPI) ? EXEC : RDB;
         RDB:   if (xferDone) nextState = (irOp == OP_CPI && !irImm) ? RDIND : EXEC;
         RDIND: if (xferDone) nextState = EXEC;
         EXEC: begin
            if (irOp == OP_BZJ)
               nextState = (bzjTarget == pcReg) ? HALT : FETCH;
            else
               nextState = WRITE;
         end
         WRITE:   if (xferDone) nextState = FETCH;
         HALT:    nextState = HALT;
         default: nextState = FETCH;
      endcase
   end

   // Bus outputs are forced idle while rst is high so a reset cuts a transfer short at once
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!rst) begin
         case (state)
            FETCH: begin
               mem_req  = 1'b1;
               mem_addr = pcReg;
            end
            RDA: begin
               mem_req  = 1'b1;
               mem_addr = aAddr;
            end
            RDB: begin
               mem_req  = 1'b1;
               mem_addr = bAddr;
            end
            RDIND: begin
               mem_req  = 1'b1;
               mem_addr = opB[ADDR_W-1:0];
            end
            WRITE: begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = (irOp == OP_CPI && irImm) ? opA[ADDR_W-1:0] : aAddr;
               mem_wdata = res;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcReg <= '0;
         ir    <= '0;
         opA   <= '0;
         opB   <= '0;
         res   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            FETCH:      if (xferDone) ir <= rdWord;
            RDA:        if (xferDone) opA <= mem_rdata;
            RDB, RDIND: if (xferDone) opB <= mem_rdata;
            EXEC: begin
               if (irOp == OP_BZJ) begin
                  pcReg <= bzjTarget;
                  cnt   <= cnt + CNT_W'(1);
               end else begin
                  res <= aluRes;
               end
            end
            WRITE: begin
               if (xferDone) begin
                  pcReg <= pcReg + ADDR_W'(1);
                  cnt   <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign halted      = (state == HALT);
   assign pc          = pcReg;
   assign instr_count = cnt;

endmodule

// File: tb/tb_simple_cpu_hs.sv
// tb/tb_simple_cpu_hs.sv - directed self-checking bench for simple_cpu_hs
module tb_simple_cpu_hs;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = 32;

   localparam logic [2:0] ADD = 3'd0, NAND = 3'd1, SRL = 3'd2, LT = 3'd3;
   localparam logic [2:0] CP = 3'd4, CPI = 3'd5, BZJ = 3'd6, MUL = 3'd7;
   localparam int ZERO_LOC = 900;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              mem_ack = 1'b1;
   logic              halted;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0]  instr_count;

   logic [DATA_W-1:0] ram [0:1023];
   logic              loadEn = 1'b0, loadClr = 1'b0;
   logic [ADDR_W-1:0] loadAddr = '0;
   logic [DATA_W-1:0] loadData = '0;

   bit                ackRandom = 1'b0, forceAckLow = 1'b0;
   int                waitLeft = 0;
   bit                inXfer = 1'b0, pendPrev = 1'b0;
   int                stabErr = 0;
   logic [ADDR_W-1:0] savedAddr = '0;
   logic              savedWe = 1'b0;
   logic [DATA_W-1:0] savedWdata = '0;

   int nChecks = 0;
   int nFails  = 0;
   int reqSeen;

   always #5 clk = ~clk;

   simple_cpu_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .halted      (halted),
      .pc          (pc),
      .instr_count (instr_count)
   );

   always @(posedge clk) begin
      if (loadClr) begin
         for (int i = 0; i < 1024; i++) ram[i] <= '0;
      end else if (loadEn) begin
         ram[loadAddr] <= loadData;
      end else if (mem_req && mem_ack && mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
   end

   assign mem_rdata = ram[mem_addr];

   // Ack driver plus bus-stability monitor across wait states
   always @(negedge clk) begin
      if (rst) begin
         pendPrev = 1'b0;
         inXfer   = 1'b0;
      end else if (pendPrev && mem_req &&
                   (mem_addr !== savedAddr || mem_we !== savedWe ||
                    (mem_we && mem_wdata !== savedWdata))) begin
         stabErr++;
      end
      if (forceAckLow) begin
         mem_ack = 1'b0;
      end else if (!ackRandom) begin
         mem_ack = 1'b1;
      end else if (mem_req) begin
         if (!inXfer) begin
            waitLeft = $urandom_range(0, 3);
            inXfer   = 1'b1;
         end
         if (waitLeft == 0) begin
            mem_ack = 1'b1;
            inXfer  = 1'b0;
         end else begin
            mem_ack = 1'b0;
            waitLeft--;
         end
      end else begin
         mem_ack = 1'($urandom_range(0, 1));
      end
      pendPrev   = mem_req && !mem_ack && !rst;
      savedAddr  = mem_addr;
      savedWe    = mem_we;
      savedWdata = mem_wdata;
   end

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [2:0] op, input logic imm, input int a, input int b);
      return {op, imm, a[13:0], b[13:0]};
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic loadStart();
      rst         = 1'b1;
      ackRandom   = 1'b0;
      forceAckLow = 1'b0;
      loadClr     = 1'b1;
      @(posedge clk);
      #1 loadClr = 1'b0;
   endtask

   task automatic poke(input int a, input logic [31:0] d);
      loadAddr = ADDR_W'(a);
      loadData = d;
      loadEn   = 1'b1;
      @(posedge clk);
      #1 loadEn = 1'b0;
   endtask

   task automatic waitHalt(input string tag, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkEq(tag, halted, 1);
   endtask

   task automatic loadAddProg();
      loadStart();
      poke(0, enc(ADD, 0, 100, 101));
      poke(1, enc(BZJ, 1, ZERO_LOC, 1));
      poke(100, 7);
      poke(101, 5);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cycles(3);
      checkEq("rst_req", mem_req, 0);
      checkEq("rst_we", mem_we, 0);
      checkEq("rst_addr", mem_addr, 0);
      checkEq("rst_wdata", mem_wdata, 0);
      checkEq("rst_pc", pc, 0);
      checkEq("rst_count", instr_count, 0);
      checkEq("rst_halted", halted, 0);

      // ADD reg with zero-wait memory
      loadAddProg();
      rst = 1'b0;
      #1;
      checkEq("first_fetch_req", mem_req, 1);
      checkEq("first_fetch_addr", mem_addr, 0);
      cycles(4);
      checkEq("add_pc_before", pc, 0);
      checkEq("add_mem_before", ram[100], 7);
      cycles(1);
      checkEq("add_mem", ram[100], 12);
      checkEq("add_pc", pc, 1);
      checkEq("add_count", instr_count, 1);
      waitHalt("add_halt", 20);
      checkEq("add_halt_count", instr_count, 2);
      checkEq("add_halt_pc", pc, 1);
      reqSeen = 0;
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         if (mem_req) reqSeen++;
      end
      checkEq("halt_no_req", reqSeen, 0);

      // Same program with random wait states
      loadAddProg();
      ackRandom = 1'b1;
      rst       = 1'b0;
      waitHalt("rand_halt", 300);
      checkEq("rand_mem100", ram[100], 12);
      checkEq("rand_mem101", ram[101], 5);
      checkEq("rand_count", instr_count, 2);
      checkEq("rand_stable", stabErr, 0);

      // SRL boundaries
      loadStart();
      poke(0, enc(SRL, 1, 100, 4));
      poke(1, enc(SRL, 1, 101, 33));
      poke(2, enc(SRL, 1, 102, 70));
      poke(3, enc(BZJ, 1, ZERO_LOC, 3));
      poke(100, 32'h8000_0001);
      poke(101, 32'h8000_0001);
      poke(102, 32'h8000_0001);
      rst = 1'b0;
      waitHalt("srl_halt", 100);
      checkEq("srl_v4", ram[100], 32'h0800_0000);
      checkEq("srl_v33", ram[101], 32'h0000_0002);
      checkEq("srl_v70", ram[102], 32'h0000_0000);
      checkEq("srl_count", instr_count, 4);

      // NAND / LT / CP / MUL / ADD wrap
      loadStart();
      poke(0, enc(NAND, 0, 110, 111));
      poke(1, enc(LT, 1, 112, 10));
      poke(2, enc(LT, 0, 113, 114));
      poke(3, enc(CP, 1, 115, 'h1234));
      poke(4, enc(MUL, 0, 116, 117));
      poke(5, enc(ADD, 1, 118, 1));
      poke(6, enc(CP, 0, 119, 110));
      poke(7, enc(BZJ, 1, ZERO_LOC, 7));
      poke(110, 32'hF0F0_F0F0);
      poke(111, 32'hFF00_FF00);
      poke(112, 9);
      poke(113, 5);
      poke(114, 5);
      poke(116, 32'h0001_0001);
      poke(117, 32'h0001_0003);
      poke(118, 32'hFFFF_FFFF);
      rst = 1'b0;
      waitHalt("ops_halt", 200);
      checkEq("nand", ram[110], 32'h0FFF_0FFF);
      checkEq("lt_true", ram[112], 1);
      checkEq("lt_equal", ram[113], 0);
      checkEq("cp_imm", ram[115], 32'h0000_1234);
      checkEq("mul_low", ram[116], 32'h0004_0003);
      checkEq("add_wrap", ram[118], 0);
      checkEq("cp_reg", ram[119], 32'h0FFF_0FFF);
      checkEq("ops_count", instr_count, 8);

      // CPI both forms, with exact zero-wait latency to HALT
      loadStart();
      poke(0, enc(CPI, 0, 100, 101));
      poke(1, enc(CPI, 1, 102, 103));
      poke(2, enc(BZJ, 1, ZERO_LOC, 2));
      poke(101, 200);
      poke(200, 'hAB);
      poke(102, 300);
      poke(103, 'h55);
      rst = 1'b0;
      cycles(12);
      checkEq("cpi_not_yet_halted", halted, 0);
      cycles(1);
      checkEq("cpi_halted_at_13", halted, 1);
      checkEq("cpi_load", ram[100], 'hAB);
      checkEq("cpi_store", ram[300], 'h55);
      checkEq("cpi_count", instr_count, 3);

      // BZJ reg taken, then not taken
      loadStart();
      poke(0, enc(BZJ, 0, 120, 121));
      poke(3, enc(BZJ, 0, 122, 123));
      poke(4, enc(BZJ, 1, ZERO_LOC, 4));
      poke(120, 3);
      poke(123, 7);
      rst = 1'b0;
      cycles(4);
      checkEq("bzj_taken_pc", pc, 3);
      checkEq("bzj_taken_count", instr_count, 1);
      cycles(4);
      checkEq("bzj_fall_pc", pc, 4);
      checkEq("bzj_fall_count", instr_count, 2);
      waitHalt("bzj_halt", 20);
      checkEq("bzj_halt_count", instr_count, 3);

      // PC wrap from the top of the address space
      loadStart();
      poke(0, enc(BZJ, 0, 132, 133));
      poke(1, enc(BZJ, 1, ZERO_LOC, 1));
      poke(1023, enc(CP, 1, 133, 1));
      poke(132, 1023);
      rst = 1'b0;
      cycles(4);
      checkEq("wrap_jump_pc", pc, 1023);
      waitHalt("wrap_halt", 100);
      checkEq("wrap_pc", pc, 1);
      checkEq("wrap_count", instr_count, 4);
      checkEq("wrap_flag", ram[133], 1);

      // Reset while stalled in RDB
      loadStart();
      poke(0, enc(CP, 1, 140, 9));
      poke(1, enc(ADD, 0, 141, 142));
      rst = 1'b0;
      cycles(5);
      forceAckLow = 1'b1;
      cycles(3);
      checkEq("stall_req", mem_req, 1);
      checkEq("stall_addr", mem_addr, 142);
      checkEq("stall_pc", pc, 1);
      checkEq("stall_count", instr_count, 1);
      checkEq("stall_cp", ram[140], 9);
      #2 rst = 1'b1;
      #1;
      checkEq("midrst_req", mem_req, 0);
      checkEq("midrst_pc", pc, 0);
      checkEq("midrst_count", instr_count, 0);
      @(posedge clk);
      #1;
      forceAckLow = 1'b0;
      rst         = 1'b0;
      #1;
      checkEq("refetch_req", mem_req, 1);
      checkEq("refetch_addr", mem_addr, 0);
      checkEq("refetch_we", mem_we, 0);
      cycles(3);
      checkEq("rerun_pc", pc, 1);
      checkEq("rerun_count", instr_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
